// File: rtl/multi_channel_stream_cipher_if.sv
// Valid/ready word stream carrying one bit per cipher channel.
//   valid : word valid, driven by the producer
//   ready : consumer accepts the word this cycle
//   data  : N_CH-bit word, bit c belongs to channel c
// Modports: master = producer side, slave = consumer side.
interface multi_channel_stream_cipher_if #(
  parameter int unsigned N_CH = 2
);
  logic            valid;
  logic            ready;
  logic [N_CH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/multi_channel_stream_cipher.sv
// N_CH-channel XOR stream cipher. Each channel owns a W-bit Galois LFSR keystream with its own
// taps, seed and bypass bit, all loaded through one daisy-chainable serial config shift chain.
// Data moves through a valid/ready handshake with a 1-entry registered output stage.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   cfg_en     : config shift mode; the data path is frozen while high
//   cfg_i      : serial config in, enters at the chain MSB
//   cfg_o      : chain LSB while cfg_en, else 0 (daisy-chain to the next block)
//   cfg_done   : one-cycle pulse once a full chain has been shifted and seeds loaded
//   in_if      : input word stream (slave)
//   out_if     : ciphered word stream (master), latency 1 cycle
//   heartbeat  : liveness indicator
//
// Optional feature macro: CIPHER_HEARTBEAT_EN builds a free-running HB_BITS counter whose top
// three bits drive heartbeat; without it heartbeat is tied to 0.
module multi_channel_stream_cipher #(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned W        = 32,
  parameter logic [31:0] TAPS_DEF = 32'h4800_0000,
  parameter logic [31:0] SEED_DEF = 32'h0000_0055,
  parameter int unsigned HB_BITS  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_en,
  input  logic                          cfg_i,
  output logic                          cfg_o,
  output logic                          cfg_done,
  multi_channel_stream_cipher_if.slave  in_if,
  multi_channel_stream_cipher_if.master out_if,
  output logic [2:0]                    heartbeat
);

  localparam int unsigned ChLen  = 2 * W + 1;
  localparam int unsigned CfgLen = N_CH * ChLen;
  localparam int unsigned CntW   = $clog2(CfgLen + 1);

  // An all-zero seed would lock the LFSR, so it loads as 1.
  localparam logic [W-1:0]      SeedRst  = (SEED_DEF[W-1:0] == '0) ? W'(1) : SEED_DEF[W-1:0];
  localparam logic [ChLen-1:0]  ChRst    = {1'b0, TAPS_DEF[W-1:0], SEED_DEF[W-1:0]};
  localparam logic [CfgLen-1:0] ChainRst = {N_CH{ChRst}};

  if (N_CH < 1 || N_CH > 8 || W < 8 || W > 32 || HB_BITS < 4) begin : gen_param_check
    $error("multi_channel_stream_cipher: parameter out of range");
  end

  // Per-channel field layout inside the chain: {bypass, taps, seed}.
  function automatic logic [W-1:0] ch_seed(logic [CfgLen-1:0] chain, int unsigned c);
    return chain[c*ChLen +: W];
  endfunction

  function automatic logic [W-1:0] ch_taps(logic [CfgLen-1:0] chain, int unsigned c);
    return chain[c*ChLen + W +: W];
  endfunction

  function automatic logic ch_bypass(logic [CfgLen-1:0] chain, int unsigned c);
    return chain[c*ChLen + 2*W];
  endfunction

  logic [CfgLen-1:0]         chain_q, chain_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic [N_CH-1:0][W-1:0]    state_q, state_d;
  logic                      out_valid_q, out_valid_d;
  logic [N_CH-1:0]           out_data_q, out_data_d;
  logic                      in_ready;
  logic                      accept;

  // Config chain and shift counter. done_d marks the CFG_LEN-th consecutive shift; seeds are
  // taken from chain_d so states and cfg_done update on the same edge.
  always_comb begin
    chain_d = chain_q;
    cnt_d   = '0;
    done_d  = 1'b0;
    if (cfg_en) begin
      chain_d = {cfg_i, chain_q[CfgLen-1:1]};
      if (cnt_q == CntW'(CfgLen - 1)) begin
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign in_ready = !cfg_en && (!out_valid_q || out_if.ready);
  assign accept   = in_if.valid && in_ready;

  // Keystream and output stage. Seed load needs cfg_en and accept needs !cfg_en, so the two
  // never collide.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (done_d) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        state_d[c] = (ch_seed(chain_d, c) == '0) ? W'(1) : ch_seed(chain_d, c);
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      for (int unsigned c = 0; c < N_CH; c++) begin
        state_d[c]    = (state_q[c] >> 1) ^ (state_q[c][0] ? ch_taps(chain_q, c) : '0);
        out_data_d[c] = ch_bypass(chain_q, c) ? in_if.data[c] : (in_if.data[c] ^ state_q[c][0]);
      end
    end else if (out_if.ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q     <= ChainRst;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      state_q     <= {N_CH{SeedRst}};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      chain_q     <= chain_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign cfg_o        = cfg_en & chain_q[0];
  assign cfg_done     = done_q;
  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;

`ifdef CIPHER_HEARTBEAT_EN
  logic [HB_BITS-1:0] hb_cnt_q, hb_cnt_d;

  always_comb begin
    hb_cnt_d = hb_cnt_q + HB_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt_q <= '0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
    end
  end

  assign heartbeat = hb_cnt_q[HB_BITS-1 -: 3];
`else
  assign heartbeat = 3'b000;
`endif

endmodule

// File: tb/tb_multi_channel_stream_cipher.sv
// Directed bench for multi_channel_stream_cipher (W=8, N_CH=2, HB_BITS=4). Instance A is the
// encryptor; instance B shares the config chain and decrypts A's ciphertext.
module tb_multi_channel_stream_cipher;
  localparam int unsigned N_CH    = 2;
  localparam int unsigned W       = 8;
  localparam int unsigned CFG_LEN = N_CH * (2 * W + 1);
  localparam logic [CFG_LEN-1:0] CfgA = {1'b1, 8'hB8, 8'h01, 1'b0, 8'hB8, 8'h01};
  localparam logic [CFG_LEN-1:0] CfgZ = {1'b1, 8'hB8, 8'h00, 1'b0, 8'hB8, 8'h00};

  logic       clk;
  logic       rst;
  logic       cfg_en;
  logic       cfg_i;
  logic       a_cfg_o, a_cfg_done, b_cfg_o, b_cfg_done;
  logic [2:0] a_hb, b_hb;
  int         checks;
  int         errors;

  multi_channel_stream_cipher_if #(.N_CH(N_CH)) a_in_if ();
  multi_channel_stream_cipher_if #(.N_CH(N_CH)) a_out_if ();
  multi_channel_stream_cipher_if #(.N_CH(N_CH)) b_in_if ();
  multi_channel_stream_cipher_if #(.N_CH(N_CH)) b_out_if ();

  multi_channel_stream_cipher #(.N_CH(N_CH), .W(W), .HB_BITS(4)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .cfg_en   (cfg_en),
    .cfg_i    (cfg_i),
    .cfg_o    (a_cfg_o),
    .cfg_done (a_cfg_done),
    .in_if    (a_in_if),
    .out_if   (a_out_if),
    .heartbeat(a_hb)
  );

  multi_channel_stream_cipher #(.N_CH(N_CH), .W(W), .HB_BITS(4)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .cfg_en   (cfg_en),
    .cfg_i    (cfg_i),
    .cfg_o    (b_cfg_o),
    .cfg_done (b_cfg_done),
    .in_if    (b_in_if),
    .out_if   (b_out_if),
    .heartbeat(b_hb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift n bits of w LSB-first, then one idle cycle; counts cfg_done pulses on instance A.
  task automatic shift_cfg(input logic [CFG_LEN-1:0] w, input int n,
                           output int pulses, output int pulse_at);
    pulses   = 0;
    pulse_at = -1;
    for (int i = 0; i < n; i++) begin
      cfg_en = 1'b1;
      cfg_i  = w[i];
      @(posedge clk); #1;
      if (a_cfg_done) begin pulses++; pulse_at = i + 1; end
    end
    cfg_en = 1'b0;
    cfg_i  = 1'b0;
    @(posedge clk); #1;
    if (a_cfg_done) begin pulses++; pulse_at = n + 1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_en = 1'b0; cfg_i = 1'b0;
    a_in_if.valid = 1'b0; a_in_if.data = '0; a_out_if.ready = 1'b1;
    b_in_if.valid = 1'b0; b_in_if.data = '0; b_out_if.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_out_if.valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b expected 0", a_out_if.valid); end
    checks++; if (a_out_if.data !== 2'b00) begin errors++;
      $display("FAIL reset_out_data: got %b expected 00", a_out_if.data); end
    checks++; if (a_cfg_done !== 1'b0) begin errors++;
      $display("FAIL reset_cfg_done: got %b expected 0", a_cfg_done); end
    checks++; if (a_cfg_o !== 1'b0) begin errors++;
      $display("FAIL reset_cfg_o: got %b expected 0", a_cfg_o); end
    checks++; if (a_hb !== 3'b000) begin errors++;
      $display("FAIL reset_heartbeat: got %b expected 000", a_hb); end
    checks++; if (a_in_if.ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %b expected 1", a_in_if.ready); end
    rst = 1'b0;
  endtask

  task automatic test_config_load();
    int pulses, at;
    shift_cfg(CfgA, CFG_LEN, pulses, at);
    checks++; if (pulses != 1) begin errors++;
      $display("FAIL cfg_done_count: got %0d expected 1", pulses); end
    checks++; if (at != CFG_LEN) begin errors++;
      $display("FAIL cfg_done_timing: got shift %0d expected %0d", at, CFG_LEN); end
  endtask

  // Five words back-to-back: ch0 keystream 1,0,0,0,1; ch1 bypassed.
  task automatic test_keystream();
    logic [1:0] exp [5];
    exp = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    a_out_if.ready = 1'b1;
    a_in_if.valid  = 1'b1;
    a_in_if.data   = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (a_in_if.ready !== 1'b1) begin errors++;
        $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, a_in_if.ready); end
      @(posedge clk); #1;
      checks++; if (a_out_if.valid !== 1'b1 || a_out_if.data !== exp[i]) begin errors++;
        $display("FAIL keystream[%0d]: got v=%b d=%b expected v=1 d=%b",
                 i, a_out_if.valid, a_out_if.data, exp[i]); end
    end
    a_in_if.valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_out_if.valid !== 1'b0) begin errors++;
      $display("FAIL drain_out_valid: got %b expected 0", a_out_if.valid); end
  endtask

  task automatic test_decrypt();
    logic ct [5];
    ct = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    b_out_if.ready = 1'b1;
    b_in_if.valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_in_if.data = {1'b0, ct[i]};
      @(posedge clk); #1;
      checks++; if (b_out_if.valid !== 1'b1 || b_out_if.data !== 2'b00) begin errors++;
        $display("FAIL decrypt[%0d]: got v=%b d=%b expected v=1 d=00",
                 i, b_out_if.valid, b_out_if.data); end
    end
    b_in_if.valid = 1'b0;
    b_in_if.data  = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int pulses, at;
    shift_cfg(CfgA, CFG_LEN, pulses, at);
    checks++; if (pulses != 1) begin errors++;
      $display("FAIL stall_reload: got %0d pulses expected 1", pulses); end
    a_out_if.ready = 1'b0;
    a_in_if.valid  = 1'b1;
    a_in_if.data   = 2'b00;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_in_if.ready !== 1'b0) begin errors++;
        $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, a_in_if.ready); end
      checks++; if (a_out_if.valid !== 1'b1 || a_out_if.data !== 2'b01) begin errors++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%b expected v=1 d=01",
                 i, a_out_if.valid, a_out_if.data); end
      @(posedge clk); #1;
    end
    a_out_if.ready = 1'b1;
    #1;
    checks++; if (a_in_if.ready !== 1'b1) begin errors++;
      $display("FAIL release_in_ready: got %b expected 1", a_in_if.ready); end
    @(posedge clk); #1;
    checks++; if (a_out_if.valid !== 1'b1 || a_out_if.data !== 2'b00) begin errors++;
      $display("FAIL after_stall_word: got v=%b d=%b expected v=1 d=00",
               a_out_if.valid, a_out_if.data); end
    a_in_if.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // 10-bit partial shift: no load, states continue from 5C (keystream 0,0,1); ch1 bypass
  // becomes 0 because zeros were shifted into its bypass position.
  task automatic test_partial_load();
    int         pulses;
    logic [1:0] exp [3];
    exp = '{2'b00, 2'b00, 2'b11};
    pulses = 0;
    checks++; if (a_cfg_o !== 1'b0) begin errors++;
      $display("FAIL cfg_o_idle: got %b expected 0", a_cfg_o); end
    cfg_en = 1'b1;
    cfg_i  = 1'b0;
    #1;
    checks++; if (a_cfg_o !== 1'b1) begin errors++;
      $display("FAIL cfg_o_lsb: got %b expected 1", a_cfg_o); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (a_cfg_done) pulses++;
      if (i == 0) begin
        checks++; if (a_cfg_o !== 1'b0) begin errors++;
          $display("FAIL cfg_o_shifted: got %b expected 0", a_cfg_o); end
      end
    end
    cfg_en = 1'b0;
    @(posedge clk); #1;
    if (a_cfg_done) pulses++;
    checks++; if (pulses != 0) begin errors++;
      $display("FAIL partial_no_done: got %0d pulses expected 0", pulses); end
    a_in_if.valid = 1'b1;
    a_in_if.data  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (a_out_if.valid !== 1'b1 || a_out_if.data !== exp[i]) begin errors++;
        $display("FAIL partial_keystream[%0d]: got v=%b d=%b expected v=1 d=%b",
                 i, a_out_if.valid, a_out_if.data, exp[i]); end
    end
    a_in_if.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_seed();
    int         pulses, at;
    logic [1:0] exp [2];
    exp = '{2'b01, 2'b00};
    shift_cfg(CfgZ, CFG_LEN, pulses, at);
    checks++; if (pulses != 1) begin errors++;
      $display("FAIL zero_seed_done: got %0d pulses expected 1", pulses); end
    a_in_if.valid = 1'b1;
    a_in_if.data  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (a_out_if.data !== exp[i]) begin errors++;
        $display("FAIL zero_seed_keystream[%0d]: got %b expected %b", i, a_out_if.data, exp[i]); end
    end
    a_in_if.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reset restores seed 55 with zero taps (low 8 bits of 48000000): keystream 1,0,1 on both.
  task automatic test_reset_midstream();
    logic [1:0] exp [3];
    exp = '{2'b11, 2'b00, 2'b11};
    a_out_if.ready = 1'b0;
    a_in_if.valid  = 1'b1;
    a_in_if.data   = 2'b00;
    @(posedge clk); #1;
    checks++; if (a_out_if.valid !== 1'b1) begin errors++;
      $display("FAIL pre_reset_pending: got %b expected 1", a_out_if.valid); end
    a_in_if.valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (a_out_if.valid !== 1'b0 || a_out_if.data !== 2'b00) begin errors++;
      $display("FAIL reset_discard: got v=%b d=%b expected v=0 d=00",
               a_out_if.valid, a_out_if.data); end
    checks++; if (a_cfg_o !== 1'b0 || a_cfg_done !== 1'b0) begin errors++;
      $display("FAIL reset_cfg_outputs: got cfg_o=%b done=%b expected 0 0", a_cfg_o, a_cfg_done); end
    a_out_if.ready = 1'b1;
    a_in_if.valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (a_out_if.data !== exp[i]) begin errors++;
        $display("FAIL reset_keystream[%0d]: got %b expected %b", i, a_out_if.data, exp[i]); end
    end
    a_in_if.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_heartbeat();
    logic [2:0] hb_exp;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 18; n++) begin
`ifdef CIPHER_HEARTBEAT_EN
      hb_exp = 3'((n % 16) / 2);
`else
      hb_exp = 3'b000;
`endif
      checks++; if (a_hb !== hb_exp) begin errors++;
        $display("FAIL heartbeat[%0d]: got %b expected %b", n, a_hb, hb_exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_config_load();
    test_keystream();
    test_decrypt();
    test_stall();
    test_partial_load();
    test_zero_seed();
    test_reset_midstream();
    test_heartbeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
